// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Signed operations run on magnitudes; signs are applied in a single fix-up cycle.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wd,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   logic               a_neg_q, a_neg_d, b_neg_q, b_neg_d, b_zero_q, b_zero_d;
   logic [WIDTH-1:0]   b_q, b_d, hi_q, hi_d, lo_q, lo_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic               done_q, done_d;

   logic               in_signed, a_sgn, b_sgn, is_div, signed_op, div_ge;
   logic [WIDTH-1:0]   a_abs, b_abs, div_rem;
   logic [WIDTH:0]     mul_sum, div_sh;
   logic [2*WIDTH-1:0] acc_neg;

   assign in_signed = ~op[0];
   assign a_sgn     = in_signed & srca[WIDTH-1];
   assign b_sgn     = in_signed & srcb[WIDTH-1];
   assign a_abs     = a_sgn ? -srca : srca;
   assign b_abs     = b_sgn ? -srcb : srcb;

   assign is_div    = op_q[1];
   assign signed_op = ~op_q[0];

   // Multiply: acc = {partial product, remaining multiplier bits}.
   assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
   // Divide: acc = {remainder, dividend bits turning into quotient bits}.
   assign div_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_ge  = div_sh >= {1'b0, b_q};
   assign div_rem = div_sh[WIDTH-1:0] - b_q;
   assign acc_neg = -acc_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      a_neg_d  = a_neg_q;
      b_neg_d  = b_neg_q;
      b_zero_d = b_zero_q;
      b_d      = b_q;
      acc_d    = acc_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d     = op;
               a_neg_d  = a_sgn;
               b_neg_d  = b_sgn;
               b_zero_d = (srcb == '0);
               b_d      = b_abs;
               acc_d    = {{WIDTH{1'b0}}, a_abs};
               cnt_d    = CW'(WIDTH - 1);
               state_d  = S_CALC;
            end else begin
               if (hi_we) hi_d = wd;
               if (lo_we) lo_d = wd;
            end
         end
         S_CALC: begin
            if (is_div) begin
               acc_d = div_ge ? {div_rem, acc_q[WIDTH-2:0], 1'b1}
                              : {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
            if (cnt_q == '0) state_d = S_FIX;
            else             cnt_d   = cnt_q - CW'(1);
         end
         S_FIX: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (is_div) begin
               // A zero divisor leaves quotient all ones, so its sign is never applied.
               hi_d = (signed_op && a_neg_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
               lo_d = (signed_op && (a_neg_q ^ b_neg_q) && !b_zero_q) ? -acc_q[WIDTH-1:0]
                                                                       : acc_q[WIDTH-1:0];
            end else begin
               {hi_d, lo_d} = (signed_op && (a_neg_q ^ b_neg_q)) ? acc_neg : acc_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         b_zero_q <= 1'b0;
         b_q      <= '0;
         acc_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         a_neg_q  <= a_neg_d;
         b_neg_q  <= b_neg_d;
         b_zero_q <= b_zero_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO come from plain 64-bit arithmetic,
// and a monitor checks every done pulse against the queue in issue order.
module tb_muldiv_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset, start, hi_we, lo_we, busy, done;
   logic [1:0]   op;
   logic [W-1:0] srca, srcb, wd, hi, lo;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           cyc;
   } exp_t;

   exp_t         sb_q[$];
   int           cyc = 0;
   int           n_checks = 0;
   int           n_pass = 0;
   logic [W-1:0] model_hi = '0, model_lo = '0, prev_hi, prev_lo;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
      .hi_we(hi_we), .lo_we(lo_we), .wd(wd), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
      longint      sa, sb, q, r;
      logic [63:0] res, qv, rv;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = '0;
      case (o)
         2'b00: res = 64'(sa * sb);
         2'b01: res = {32'd0, a} * {32'd0, b};
         default: begin
            if (b == '0) res = {a, 32'hFFFF_FFFF};
            else if (o == 2'b10) begin
               q = sa / sb; r = sa % sb; qv = q; rv = r;
               res = {rv[31:0], qv[31:0]};
            end else res = {a % b, a / b};
         end
      endcase
      return res;
   endfunction

   // Monitor: every done pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (!reset && done) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("result_hi", hi, e.hi);
            check("result_lo", lo, e.lo);
            check("latency", 32'(cyc - e.cyc), 32'(W + 1));
         end
      end
   end

   task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic with_lo_we);
      logic [63:0] r;
      exp_t        e;
      op = o; srca = a; srcb = b; start = 1'b1;
      lo_we = with_lo_we; wd = 32'h5555_AAAA;
      @(posedge clk); #1;
      start = 1'b0; lo_we = 1'b0;
      op = 2'($urandom); srca = $urandom; srcb = $urandom;
      r = ref_model(o, a, b);
      e.hi = r[63:32]; e.lo = r[31:0]; e.cyc = cyc;
      sb_q.push_back(e);
      check("start_accepted", 32'(busy), 32'd1);
      prev_hi = model_hi; prev_lo = model_lo;
      model_hi = r[63:32]; model_lo = r[31:0];
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("idle_reached", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      op = '0; srca = '0; srcb = '0; wd = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // mult with busy-length measurement, then back-to-back multu in the done cycle.
      issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
      n = 0;
      while (busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("busy_cycles", 32'(n), 32'(W + 1));
      check("done_when_idle", 32'(done), 32'd1);
      issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
      wait_idle();

      issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
      wait_idle();
      issue(2'b11, 32'd100, 32'd7, 1'b0);
      wait_idle();
      issue(2'b11, 32'h0000_1234, 32'h0, 1'b0);
      wait_idle();
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      wait_idle();
      issue(2'b10, 32'hFFFF_FF00, 32'h0, 1'b0);
      wait_idle();

      // start pulsed mid-operation must be ignored.
      issue(2'b11, 32'd100, 32'd7, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; op = 2'b00; srca = 32'd9; srcb = 32'd9;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle();
      @(posedge clk); #1;
      check("restart_ignored", 32'(busy), 32'd0);

      // hi_we during busy is ignored; HI holds its old value through CALC.
      issue(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      hi_we = 1'b1; wd = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      hi_we = 1'b0;
      check("hi_hold_busy", hi, prev_hi);
      check("lo_hold_busy", lo, prev_lo);
      wait_idle();

      // Direct writes in IDLE.
      hi_we = 1'b1; wd = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      hi_we = 1'b0;
      check("mthi_hi", hi, 32'hDEAD_BEEF);
      check("mthi_lo_unchanged", lo, model_lo);
      model_hi = 32'hDEAD_BEEF;
      hi_we = 1'b1; lo_we = 1'b1; wd = 32'h0BAD_F00D;
      @(posedge clk); #1;
      hi_we = 1'b0; lo_we = 1'b0;
      check("both_we_hi", hi, 32'h0BAD_F00D);
      check("both_we_lo", lo, 32'h0BAD_F00D);
      model_hi = 32'h0BAD_F00D; model_lo = 32'h0BAD_F00D;

      // start together with lo_we: the write is dropped.
      issue(2'b11, 32'd1000, 32'd33, 1'b1);
      check("lo_we_dropped", lo, prev_lo);
      wait_idle();

      // Reset in the middle of a divide.
      issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
      repeat (9) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_done", 32'(done), 32'd0);
      check("midreset_hi", hi, 32'd0);
      check("midreset_lo", lo, 32'd0);
      sb_q.delete();
      model_hi = '0; model_lo = '0;
      @(posedge clk); #1;
      reset = 1'b0;
      issue(2'b01, 32'd3, 32'd5, 1'b0);
      wait_idle();

      // Randomised operations, biased toward interesting divisors and dividends.
      for (int i = 0; i < 24; i++) begin
         logic [1:0]   o;
         logic [W-1:0] a, b;
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = '0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'($urandom_range(1, 15));
            3: a = 32'h8000_0000;
            default: ;
         endcase
         issue(o, a, b, 1'b0);
         wait_idle();
      end

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers. It extends the CPU datapath beyond the single-cycle ALU with signed and unsigned multiply and divide (mult, multu, div, divu) plus direct HI/LO writes (mthi, mtlo). It sits beside the ALU and is fed from the register-file read ports. It runs a radix-2 shift/add or shift/subtract loop over WIDTH cycles and stalls the core through `busy`.

## Interface
- WIDTH, 32, operand and HI/LO width; legal range is WIDTH ≥ 4.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request to begin an operation; sampled only in IDLE.
- op  in  2  operation: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
- srca  in  WIDTH  multiplicand or dividend.
- srcb  in  WIDTH  multiplier or divisor.
- hi_we  in  1  mthi write strobe.
- lo_we  in  1  mtlo write strobe.
- wd  in  WIDTH  data for hi_we and lo_we.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when HI/LO take a result.
- hi  out  WIDTH  HI register: product upper half, or remainder.
- lo  out  WIDTH  LO register: product lower half, or quotient.

## Operation
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0.
- **IDLE**
  - start=1: latch op and record both operand signs.
  - For signed ops, latch |srca| and |srcb|; for unsigned ops, latch the raw values.
  - Clear the accumulator and go to CALC with counter=WIDTH-1.
- **CALC**, one iteration per cycle:
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the upper accumulator half. Then shift the 2·WIDTH accumulator right by 1, with the WIDTH+1-bit sum carry entering at the top.
  - Divide (restoring): shift {rem,quot} left by 1 and trial-subtract the divisor from rem. If there is no borrow, keep the difference and set the quotient LSB to 1; otherwise keep rem and set the quotient LSB to 0.
  - When counter=0, go to FIX; otherwise decrement the counter.
- **FIX**, one cycle, then back to IDLE:
  - Signed mult: negate the 2·WIDTH product if the operand signs differ.
  - Signed div: negate the quotient if the signs differ, and negate the remainder if the dividend was negative. Truncation is toward zero.
  - Write hi/lo and pulse done.
- **Divide by zero** (div or divu, srcb=0): lo=all ones, hi=srca unmodified. No exception is raised and latency is unchanged.
- **Signed overflow** (most-negative ÷ -1): lo=most-negative, hi=0. This falls out of modular negation; no special case is needed.
- Absolute value of the most-negative operand is taken modulo 2^WIDTH and treated as unsigned, which gives the correct magnitude.
- **hi_we / lo_we**
  - Honoured only in IDLE with start=0: hi or lo ←wd at the edge, and both strobes may act together.
  - Ignored while busy.
  - In IDLE with start=1, start wins and the writes are dropped.
- start while busy is ignored; there is no queueing.
- op, srca and srcb are don't-care except in the cycle where start is accepted.

## Timing
- Start accepted at edge E0.
- busy=1 from after E0 until after edge E0+WIDTH+1.
- WIDTH CALC iterations occur at edges E1 through E_WIDTH.
- hi, lo and done update at edge E0+WIDTH+1, at the same edge busy falls. Latency is WIDTH+1 cycles (33 for WIDTH=32).
- done is high for exactly one cycle. A new start may be accepted in the cycle done is high, because the state is already IDLE.
- hi and lo hold their value throughout CALC and FIX, so mfhi/mflo reads old values until done.
- Mid-operation reset asynchronously forces every output and the FSM to reset values; a partial result is never written.
- hi_we/lo_we take effect at the next rising edge, and the new value is visible in the following cycle.
- No combinational path from any input to busy, done, hi or lo; all outputs are registered.

## Test plan
- **mult**: op=00, srca=0xFFFFFFFF, srcb=0x00000002.
  - Result: hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - done exactly 33 cycles after start; busy high for 33 cycles.
- **multu**: op=01, same operands.
  - Result: hi=0x00000001, lo=0xFFFFFFFE.
  - Back-to-back start issued in the done cycle is accepted.
- **div and divu**:
  - div -7/2 (0xFFFFFFF9, 0x00000002): lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu 100/7: lo=0x0000000E, hi=0x00000002.
- **Corner cases**:
  - divu 0x1234/0: lo=0xFFFFFFFF, hi=0x00001234.
  - div 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- **Handshake and writes**:
  - start pulsed again at cycle 5 of an operation is ignored, and the first result is unaffected.
  - hi_we while busy is ignored.
  - In IDLE, hi_we with wd=0xDEADBEEF gives hi=0xDEADBEEF next cycle with lo unchanged.
  - start and lo_we together: lo_we is dropped.
- **Reset mid-operation**: assert reset at cycle 10 of a div.
  - Immediately: busy=0, done=0, hi=lo=0.
  - A following multu 3×5 gives hi=0, lo=15 after 33 cycles.
